seq_detector_param: RTL and testbench

Parametrised serial sequence detector with a run-time programmable pattern and selectable overlap mode. It also keeps a saturating match counter. It replaces the fixed-pattern `sedec` detector in the lab datapath. Bits arrive MSB-first, one per qualified clock, and a registered one-cycle pulse flags each match.

---
 rtl/seqdet_pkg.sv | 20 ++
 rtl/sat_counter.sv | 27 ++
 rtl/seq_detector_param.sv | 84 ++++++++
 tb/tb_seq_detector_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and constants for the serial sequence detector.
// The config struct is sized for the widest supported pattern (32 bits).
package seqdet_pkg;

    localparam int DEF_PAT_W     = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int CFG_PAT_MAX   = 32;
    localparam int CFG_LEN_MAX_W = 8;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    typedef struct packed {
        logic [CFG_PAT_MAX-1:0]   pat;
        logic [CFG_LEN_MAX_W-1:0] len;
        logic                     ovl;
    } seqdet_cfg;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// When clr and inc are both set, the counter is cleared first and then counts once.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? W'(1) : '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial MSB-first sequence detector with a programmable pattern, length and overlap mode.
// Emits a registered one-cycle pulse per match and keeps a saturating match count.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter  int PAT_W = DEF_PAT_W,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    seqdet_cfg              r_cfg;
    logic [PAT_W-1:0]       r_hist;
    logic [LEN_W-1:0]       r_fill;
    logic                   r_out;

    logic                   w_accept;
    logic                   w_enabled;
    logic                   w_hit;
    logic [PAT_W-1:0]       w_h_next;
    logic [LEN_W-1:0]       w_f_next;
    logic [CFG_PAT_MAX-1:0] w_mask;

    always_comb begin
        w_accept  = in_valid & ~cfg_load;
        w_h_next  = {r_hist[PAT_W-2:0], in};
        w_f_next  = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);
        w_enabled = (r_cfg.len != '0) && (r_cfg.len <= CFG_LEN_MAX_W'(PAT_W));
        // Only the low cfg_len bits of history take part in the compare.
        for (int i = 0; i < CFG_PAT_MAX; i++) begin
            w_mask[i] = (CFG_LEN_MAX_W'(i) < r_cfg.len);
        end
        w_hit = w_accept && w_enabled
             && (CFG_LEN_MAX_W'(w_f_next) >= r_cfg.len)
             && (((CFG_PAT_MAX'(w_h_next) ^ r_cfg.pat) & w_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cfg  <= '{pat: '0, len: '0, ovl: 1'b1};
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (cfg_load) begin
            r_cfg.pat <= CFG_PAT_MAX'(pattern);
            r_cfg.len <= CFG_LEN_MAX_W'(pat_len);
            r_cfg.ovl <= overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_out     <= 1'b0;
        end else if (in_valid) begin
            r_out  <= w_hit;
            r_hist <= w_h_next;
            // Non-overlap mode restarts the fill so the next match needs cfg_len fresh bits.
            r_fill <= (w_hit && !r_cfg.ovl) ? '0 : w_f_next;
        end else begin
            r_out <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_hit),
        .clr  (count_clr),
        .count(match_count)
    );

    assign out = r_out;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus randomized traffic,
// all checked each cycle against a queue-based behavioural model.
module tb_seq_detector_param;

    localparam int PW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst, din, vld, load, ovl, clr;
    logic [PW-1:0] pat;
    logic [LW-1:0] plen;
    logic          out8, out2;
    logic [7:0]    cnt8;
    logic [1:0]    cnt2;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(vld), .cfg_load(load),
        .pattern(pat), .pat_len(plen), .overlap(ovl), .count_clr(clr),
        .out(out8), .match_count(cnt8)
    );

    seq_detector_param #(.PAT_W(PW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(din), .in_valid(vld), .cfg_load(load),
        .pattern(pat), .pat_len(plen), .overlap(ovl), .count_clr(clr),
        .out(out2), .match_count(cnt2)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Behavioural model: keeps the accepted bits in a queue and counts bits
    // gathered since the last restart point.
    int            m_len, m_fresh, exp_c8, exp_c2;
    logic [PW-1:0] m_pat;
    bit            m_ovl, exp_out;
    bit            hq[$];

    always @(posedge clk) begin
        bit hit;
        hit = 1'b0;
        if (!rst) begin
            m_len = 0; m_pat = '0; m_ovl = 1'b1; m_fresh = 0; hq.delete();
            exp_out = 1'b0; exp_c8 = 0; exp_c2 = 0;
            chk_en = 1'b1;
        end else begin
            if (load) begin
                m_pat = pat; m_len = int'(plen); m_ovl = ovl; m_fresh = 0; hq.delete();
            end else if (vld) begin
                hq.push_back(din);
                if (hq.size() > PW) void'(hq.pop_front());
                m_fresh = (m_fresh < PW) ? m_fresh + 1 : PW;
                if (m_len >= 1 && m_len <= PW && m_fresh >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (hq[hq.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ovl) m_fresh = 0;
            end
            exp_out = hit;
            if (clr) begin
                exp_c8 = hit ? 1 : 0;
                exp_c2 = hit ? 1 : 0;
            end else if (hit) begin
                if (exp_c8 < 255) exp_c8++;
                if (exp_c2 < 3) exp_c2++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out", out8, 32'(exp_out));
            chk("out_cnt2", out2, 32'(exp_out));
            chk("count", cnt8, exp_c8);
            chk("count_cnt2", cnt2, exp_c2);
        end
    end

    int          pulses, stray, bidx;
    logic [31:0] pmask;

    task automatic cyc(input bit b, input bit v, input bit l = 1'b0, input bit c = 1'b0);
        @(negedge clk);
        din = b; vld = v; load = l; clr = c;
        @(posedge clk);
        #1;
        if (out8) begin
            if (v && !l) begin
                pulses++;
                pmask = pmask | (32'd1 << bidx);
            end else begin
                stray++;
            end
        end
        if (v && !l) bidx++;
    endtask

    task automatic load_cfg(input logic [PW-1:0] p, input int len, input bit o,
                            input bit b = 1'b0, input bit v = 1'b0);
        pat = p; plen = LW'(len); ovl = o;
        cyc(b, v, 1'b1, 1'b0);
        pulses = 0; stray = 0; pmask = '0; bidx = 0;
    endtask

    task automatic feed(input logic [31:0] s, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(s[i], 1'b1);
            if (gap) cyc(1'b0, 1'b0);
        end
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b0; vld = 1'b0; load = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out", out8, 0);
        chk("rst_count", cnt8, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sat[5];
        sat = '{1, 2, 3, 3, 3};
        rst = 1'b0; din = 1'b0; vld = 1'b0; load = 1'b0; clr = 1'b0;
        ovl = 1'b0; pat = '0; plen = '0;
        pulses = 0; stray = 0; pmask = '0; bidx = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out8, 0);
        chk("reset_count", cnt8, 0);
        chk("reset_count2", cnt2, 0);
        @(negedge clk);
        rst = 1'b1;

        // Overlapping 1011
        load_cfg(8'b1011, 4, 1'b1);
        feed(32'b1011011010110011, 16, 1'b0);
        chk("ovl_pulse_bits", pmask, 32'h0848);
        chk("ovl_count", cnt8, 3);

        // Non-overlapping 1011
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b1011, 4, 1'b0);
        feed(32'b1011011010110011, 16, 1'b0);
        chk("novl_pulse_bits", pmask, 32'h0808);
        chk("novl_count", cnt8, 2);

        // Gapped 11
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b11, 2, 1'b1);
        feed(32'b1111, 4, 1'b1);
        chk("gap_ovl_pulses", pulses, 3);
        chk("gap_ovl_stray", stray, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'b11, 2, 1'b0);
        feed(32'b1111, 4, 1'b1);
        chk("gap_novl_pulses", pulses, 2);
        chk("gap_novl_stray", stray, 0);

        // Disabled / out of range
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        load_cfg(8'hFF, 0, 1'b1);
        feed(32'hFF, 8, 1'b0);
        chk("len0_pulses", pulses, 0);
        load_cfg(8'hFF, PW + 1, 1'b1);
        feed(32'hFF, 8, 1'b0);
        chk("len9_pulses", pulses, 0);
        chk("disabled_count", cnt8, 0);

        // Saturation and clear
        load_cfg(8'b1, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1);
            chk("sat_count2", cnt2, sat[i]);
        end
        chk("sat_count8", cnt8, 5);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_hit_count2", cnt2, 1);
        chk("clr_hit_count8", cnt8, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_only_count2", cnt2, 0);
        chk("clr_only_count8", cnt8, 0);

        // Mid-stream reset
        load_cfg(8'b1011, 4, 1'b1);
        feed(32'b101, 3, 1'b0);
        reset_cycle();
        pulses = 0;
        cyc(1'b1, 1'b1);
        chk("post_rst_pulses", pulses, 0);
        chk("post_rst_count", cnt8, 0);

        // Load coinciding with a valid bit discards that bit
        load_cfg(8'b1011, 4, 1'b1, 1'b1, 1'b1);
        feed(32'b011, 3, 1'b0);
        chk("load_discard_pulses", pulses, 0);
        load_cfg(8'b1011, 4, 1'b1);
        feed(32'b1011, 4, 1'b0);
        chk("reload_pulses", pulses, 1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst  = ($urandom_range(0, 199) != 0);
            din  = 1'($urandom);
            vld  = ($urandom_range(0, 9) < 7);
            load = ($urandom_range(0, 39) == 0);
            clr  = ($urandom_range(0, 24) == 0);
            pat  = PW'($urandom);
            plen = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 15))
                                               : LW'($urandom_range(1, 4));
            ovl  = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; vld = 1'b0; load = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
